// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampling UART receiver (8N1) feeding a small byte FIFO.
// Define UART_RX_PARITY_EN to receive one even-parity bit between data and stop.
module uart_rx_frontend #(
    parameter int unsigned CLOCK_HZ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RXD,
    output logic [7:0] Data,
    output logic       Valid,
    input  logic       Ready,
    output logic       FramingError,
    output logic       Overrun,
    output logic       ParityError
);
    localparam int unsigned DIV   = (CLOCK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q;
    logic             rxd_s1_q;
    logic             rxd_s2_q;
    logic             rxd_prev_q;
    logic [1:0]       prime_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       ph_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             fe_q;
    logic             ovr_q;
`ifdef UART_RX_PARITY_EN
    logic             pe_q;
    logic             par_bad_q;
`endif

    logic             tick;
    logic             start_edge;
    logic             sample;
    logic             push;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop;
    logic             full;
    logic             accept;

    // prime_q holds off edge detection until both the synchroniser output and the
    // edge-history flop carry real line samples, so the reset value of 1 followed
    // by a line that is already low is never mistaken for a start edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            prime_q    <= '0;
        end else begin
            rxd_s1_q   <= RXD;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign start_edge = (state_q == S_IDLE) && (prime_q == 2'd3) && rxd_prev_q && !rxd_s2_q;
    assign tick       = (div_q == DIV_W'(DIV - 1));
    assign sample     = tick && (ph_q == 4'd15);

    always_ff @(posedge Clock) begin
        if (Reset || start_edge || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    always_comb begin
        push = 1'b0;
        if (state_q == S_STOP && sample && rxd_s2_q) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q      <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            fe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    ph_q      <= '0;
                    bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_q <= 1'b0;
`endif
                    if (start_edge) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (ph_q == 4'd7) begin
                            ph_q    <= '0;
                            state_q <= rxd_s2_q ? S_IDLE : S_DATA;
                        end else begin
                            ph_q <= ph_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (ph_q == 4'd15) begin
                            ph_q      <= '0;
                            shift_q   <= {rxd_s2_q, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end
                        end else begin
                            ph_q <= ph_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (tick) begin
                        if (ph_q == 4'd15) begin
                            ph_q    <= '0;
                            state_q <= S_STOP;
                            if (rxd_s2_q != ^shift_q) begin
                                pe_q      <= 1'b1;
                                par_bad_q <= 1'b1;
                            end
                        end else begin
                            ph_q <= ph_q + 4'd1;
                        end
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_STOP: begin
                    if (tick) begin
                        if (ph_q == 4'd15) begin
                            ph_q <= '0;
                            if (rxd_s2_q) begin
                                state_q <= S_IDLE;
                            end else begin
                                fe_q    <= 1'b1;
                                state_q <= S_BREAK;
                            end
                        end else begin
                            ph_q <= ph_q + 4'd1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxd_s2_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A push into a full FIFO is still accepted when a pop frees the head slot in
    // the same cycle; the write then lands in the slot being vacated.
    assign full   = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop    = Valid && Ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= push && full && !pop;
            if (accept) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign Valid        = (count_q != '0);
    assign Data         = mem_q[rd_ptr_q];
    assign FramingError = fe_q;
    assign Overrun      = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign ParityError  = pe_q;
`else
    assign ParityError  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL provide parameter CLOCK_HZ, default 50000000: frequency of Clock in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200: serial bit rate.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4: received-byte buffer entries; a power of two, at least 2.
REQ-004 SHALL provide Clock  input  1  single clock for all logic; all ports are sampled and driven on its rising edge.
REQ-005 SHALL provide Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide RXD  input  1  asynchronous serial line; idles high.
REQ-007 SHALL provide Data  output  8  byte at the FIFO head.
REQ-008 SHALL provide Valid  output  1  FIFO not empty; Data is meaningful.
REQ-009 SHALL provide Ready  input  1  consumer accepts Data when Valid and Ready are both high in the same cycle.
REQ-010 SHALL provide FramingError  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL provide Overrun  output  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.
REQ-012 SHALL provide ParityError  output  1  one-cycle pulse on a parity mismatch; held 0 without UART_RX_PARITY_EN.

Function
REQ-013 SHALL pass RXD through a 2-flop synchroniser; all later logic uses only the synchronised value.
REQ-014 SHALL generate an oversample tick every DIV = round(CLOCK_HZ/(BAUD*16)) cycles (27 at defaults); the divider restarts on start-edge detection.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-016 IDLE: a synchronised 1-to-0 transition SHALL enter START with the tick phase counter cleared.
REQ-017 START: at tick 7 (mid-bit), RXD=0 SHALL enter DATA; RXD=1 SHALL be treated as a glitch and return to IDLE with no output.
REQ-018 DATA: SHALL sample every 16 ticks from mid start bit, 8 bits, LSB first, then enter PARITY (macro) or STOP.
REQ-019 STOP: on a mid-bit sample of 1, SHALL push the byte and return to IDLE in the same cycle, so the next start edge is detectable immediately.
REQ-020 STOP: on a mid-bit sample of 0, SHALL pulse FramingError, discard the byte and enter BREAK.
REQ-021 BREAK: SHALL remain in BREAK until RXD is sampled 1, then enter IDLE.
REQ-022 FIFO SHALL be first-in first-out; Data shall be the head entry, and a pop shall occur on Valid and Ready.
REQ-023 On push with the FIFO full and no pop, SHALL drop the new byte, pulse Overrun and leave stored contents unchanged.
REQ-024 On push and pop in the same cycle with the FIFO full, SHALL accept both with no Overrun.
REQ-025 Valid SHALL rise the cycle after the accepting stop-bit sample when the FIFO was empty.
REQ-026 Occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-027 Reset SHALL force: state IDLE, synchroniser and edge-history flops to 1, FIFO empty, Valid=0, Data=0, FramingError=0, Overrun=0, ParityError=0.
REQ-028 Reset asserted mid-frame SHALL abandon the partial byte without any error pulse.
REQ-029 After reset, a line already low SHALL NOT start a frame until a high-to-low edge is seen.

Configuration
REQ-030 With UART_RX_PARITY_EN defined, the PARITY state SHALL sample one even-parity bit after bit 7.
REQ-031 With UART_RX_PARITY_EN defined, a mismatch SHALL pulse ParityError, discard the byte, and still process the stop bit, including framing-error handling.
REQ-032 Without UART_RX_PARITY_EN, PARITY SHALL be unreachable, frames SHALL be 8N1, and ParityError SHALL be constant 0.

Verification
REQ-033 At defaults, send 8N1 byte 0xA5 -> Data=0xA5 and Valid=1 within 1 cycle after the mid-stop sample; with Ready=1 -> Valid=0 next cycle.
REQ-034 Drive a 100-cycle low glitch on idle RXD -> no Valid, no error pulses, state back in IDLE.
REQ-035 Send 0x3C with a low stop bit held low for 2 bit times -> one FramingError pulse, Valid stays 0; then 0x5A -> Data=0x5A.
REQ-036 With Ready=0, send 0x01..0x05 back to back -> Overrun pulses once on 0x05; popping returns 0x01..0x04 in order.
REQ-037 Assert Reset for 1 cycle during bit 4 of a frame -> Valid=0, no error pulses, and the next full frame 0x81 is received correctly.
REQ-038 With UART_RX_PARITY_EN, send 0x01 with parity bit 0 -> one ParityError pulse, no Valid; with parity bit 1 -> Data=0x01.
